timekeeper_hms: RTL and testbench
=================================

# timekeeper_hms

Parametrised time-of-day counter: it divides the system clock down to a one-second tick and keeps hours, minutes and seconds, wrapping at 23:59:59. It adds a programmable prescaler, a validated time-load port, day-rollover signalling and an optional alarm comparator. It replaces the fixed one-tick-per-cycle clock in the timing subsystem and feeds the display and event logic.

## Interface
- TICKS_PER_SEC, default 1: `clk` cycles per second; must be ≥1; `TICKS_PER_SEC==1` means every enabled cycle is one second.
- HOURS_PER_DAY, default 24: hour modulus; legal range 1..64; hh wraps at HOURS_PER_DAY-1.
- clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- en  in  1  count enable; gates the prescaler only.
- load  in  1  one-cycle strobe: load `ld_hh`/`ld_mm`/`ld_ss`.
- ld_hh, ld_mm, ld_ss  in  6 each  load values.
- load_err  out  1  one-cycle pulse: load rejected as out of range.
- hh, mm, ss  out  6 each  current time, registered.
- sec_en  out  1  one-cycle pulse on each second increment.
- mm_en  out  1  one-cycle pulse when ss wraps 59→0.
- hh_en  out  1  one-cycle pulse when mm wraps 59→0.
- day_en  out  1  one-cycle pulse when hh wraps to 0.
- alarm_set  in  1  strobe: capture `alarm_hh`/`alarm_mm` and arm the alarm.
- alarm_hh, alarm_mm  in  6 each  alarm time.
- alarm_ack  in  1  clears `alarm` and disarms.
- alarm  out  1  level; latched on match until acknowledged.

## Operation
- **Reset:** `hh`/`mm`/`ss`=0, prescaler=0, every pulse output=0, `load_err`=0, `alarm`=0, alarm disarmed, alarm registers=0.
- **Prescaler:** counts 0..TICKS_PER_SEC-1 while `en`=1; holds while `en`=0. A second tick occurs on the enabled cycle where the count is TICKS_PER_SEC-1; the count then returns to 0.
- **On a second tick:**
  - `ss` increments and wraps 59→0.
  - On that wrap, `mm` increments and wraps 59→0.
  - On the mm wrap, `hh` increments and wraps HOURS_PER_DAY-1→0.
  - All three digits update on the same edge; carries are combinational from the current value plus the tick, never a delayed toggle.
- **Pulses:** `sec_en`, `mm_en`, `hh_en` and `day_en` are registered. Each is high exactly in the first cycle the new value is visible; for example, `mm_en`=1 in the cycle where `ss` first reads 0 after a wrap.
- **Load:**
  - A load is accepted only if `ld_ss`≤59, `ld_mm`≤59 and `ld_hh`≤HOURS_PER_DAY-1.
  - Accepted: the digits take the load values on the next edge, the prescaler clears to 0 and no carry pulses fire.
  - Rejected: the time is unchanged, the prescaler keeps counting, and `load_err` pulses on the next cycle.
  - A load in the same cycle as a second tick wins; that tick is discarded.
- **Alarm:** behaviour with and without the feature is in Configuration.
- `en`=0 freezes the time but still honours `load`, `alarm_set` and `alarm_ack`.

## Timing
- Latency: tick edge → new digits and pulse, same edge (1 cycle after the terminal prescaler cycle). Load → new time after 1 cycle. Match → `alarm` after 1 cycle.
- Steady-state maximum pulse rates: `sec_en` 1 per TICKS_PER_SEC cycles; `day_en` 1 per 86400·TICKS_PER_SEC cycles when HOURS_PER_DAY=24.
- Reset asserted mid-count overrides everything on that edge, including `load`.
- At 23:59:59 with a tick, one edge produces 00:00:00 with `sec_en`, `mm_en`, `hh_en` and `day_en` all high in the same cycle.

## Configuration
- Macro: TIMEKEEPER_ALARM_EN.
- **Defined:**
  - `alarm_set` stores `alarm_hh`/`alarm_mm` and arms the alarm; out-of-range values are stored anyway and simply never match.
  - While armed, `alarm` latches on the second tick that makes the time equal alarm_hh:alarm_mm:00, or on an accepted load of exactly that time.
  - `alarm_ack` clears `alarm` and disarms. If ack and a match occur in the same cycle, ack wins.
  - `alarm_set` and `alarm_ack` in the same cycle: set wins (the alarm is left armed and `alarm` is cleared).
- **Undefined:** the alarm ports stay present, the inputs are ignored, `alarm` is tied 0, and no alarm registers are inferred.

## Structure
- Package `timekeeper_pkg` holds: the SEC_MAX/MIN_MAX constants (59), the digit width constant (6), and a `hms_t` packed struct {hh, mm, ss} used for the time, load and alarm buses.
- One sub-module, `mod_counter`:
  - Parameters: width, modulus.
  - Inputs: inc, load, load value.
  - Outputs: value, combinational terminal-count flag.
  - Instantiated three times, for ss, mm and hh.
- The prescaler stays in the top level, with width $clog2(TICKS_PER_SEC) (minimum 1).

## Test plan
- Reset, then TICKS_PER_SEC=4 with `en`=1 for 8 cycles → `ss`=2; `sec_en` pulses on cycles 4 and 8 only.
- Load 23:59:58, then 2 ticks → 23:59:59, then 00:00:00 with all four carry pulses high for exactly one cycle.
- Load hh=24 (HOURS_PER_DAY=24), or ld_mm=60 → time unchanged and `load_err` pulses once; then load 12:34:56 → accepted, with no pulses.
- Load coincident with a tick at 00:00:59 → loaded value shown, `mm_en`=0.
- With TIMEKEEPER_ALARM_EN: set alarm 00:01, run from 00:00:58 → `alarm` rises when the time shows 00:01:00 and stays high; `alarm_ack` clears it, and a second pass does not re-fire.
- Without TIMEKEEPER_ALARM_EN: the same stimulus → `alarm` stays 0; reset mid-count returns all outputs to 0.

Source files
------------

// File: rtl/timekeeper_pkg.sv
// Shared constants and the packed time bus for the time-of-day counter.
package timekeeper_pkg;

    localparam int DIGIT_W = 6;
    localparam logic [DIGIT_W-1:0] SEC_MAX = 6'd59;
    localparam logic [DIGIT_W-1:0] MIN_MAX = 6'd59;

    typedef struct packed {
        logic [DIGIT_W-1:0] hh;
        logic [DIGIT_W-1:0] mm;
        logic [DIGIT_W-1:0] ss;
    } hms_t;

endpackage

// File: rtl/mod_counter.sv
// Modulo-N digit counter with load priority over increment.
module mod_counter
    import timekeeper_pkg::*;
#(
    parameter int WIDTH   = DIGIT_W,
    parameter int MODULUS = 60
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] value_o,
    output logic             tc_o
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    assign tc_o    = (value_q == LAST);
    assign value_o = value_q;

    always_comb begin
        value_d = value_q;
        if (load_i) begin
            value_d = load_val_i;
        end else if (inc_i) begin
            value_d = tc_o ? '0 : value_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/timekeeper_hms.sv
// HH:MM:SS time-of-day counter with prescaler, checked load and day carry.
// Define TIMEKEEPER_ALARM_EN to build the latched alarm comparator.
module timekeeper_hms
    import timekeeper_pkg::*;
#(
    parameter int TICKS_PER_SEC = 1,
    parameter int HOURS_PER_DAY = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               load,
    input  logic [DIGIT_W-1:0] ld_hh,
    input  logic [DIGIT_W-1:0] ld_mm,
    input  logic [DIGIT_W-1:0] ld_ss,
    output logic               load_err,
    output logic [DIGIT_W-1:0] hh,
    output logic [DIGIT_W-1:0] mm,
    output logic [DIGIT_W-1:0] ss,
    output logic               sec_en,
    output logic               mm_en,
    output logic               hh_en,
    output logic               day_en,
    input  logic               alarm_set,
    input  logic [DIGIT_W-1:0] alarm_hh,
    input  logic [DIGIT_W-1:0] alarm_mm,
    input  logic               alarm_ack,
    output logic               alarm
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [DIGIT_W-1:0] HH_LAST = DIGIT_W'(HOURS_PER_DAY - 1);

    hms_t ld_v;
    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;
    logic tick, accept, tick_eff;
    logic ss_tc, mm_tc, hh_tc;
    logic mm_inc, hh_inc;
    logic sec_q, mm_en_q, hh_en_q, day_q, err_q;

    assign ld_v = '{hh: ld_hh, mm: ld_mm, ss: ld_ss};

    assign accept = load && (ld_v.ss <= SEC_MAX) &&
                    (ld_v.mm <= MIN_MAX) && (ld_v.hh <= HH_LAST);
    assign tick     = en && (pre_q == PRE_LAST);
    // An accepted load swallows a coincident tick
    assign tick_eff = tick && !accept;
    assign mm_inc   = tick_eff && ss_tc;
    assign hh_inc   = mm_inc && mm_tc;

    always_comb begin
        pre_d = pre_q;
        if (accept) begin
            pre_d = '0;
        end else if (en) begin
            pre_d = tick ? '0 : pre_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q   <= '0;
            sec_q   <= 1'b0;
            mm_en_q <= 1'b0;
            hh_en_q <= 1'b0;
            day_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            sec_q   <= tick_eff;
            mm_en_q <= mm_inc;
            hh_en_q <= hh_inc;
            day_q   <= hh_inc && hh_tc;
            err_q   <= load && !accept;
        end
    end

    mod_counter #(.WIDTH(DIGIT_W), .MODULUS(int'(SEC_MAX) + 1)) u_ss (
        .clk        (clk),
        .reset      (reset),
        .inc_i      (tick_eff),
        .load_i     (accept),
        .load_val_i (ld_v.ss),
        .value_o    (ss),
        .tc_o       (ss_tc)
    );

    mod_counter #(.WIDTH(DIGIT_W), .MODULUS(int'(MIN_MAX) + 1)) u_mm (
        .clk        (clk),
        .reset      (reset),
        .inc_i      (mm_inc),
        .load_i     (accept),
        .load_val_i (ld_v.mm),
        .value_o    (mm),
        .tc_o       (mm_tc)
    );

    mod_counter #(.WIDTH(DIGIT_W), .MODULUS(HOURS_PER_DAY)) u_hh (
        .clk        (clk),
        .reset      (reset),
        .inc_i      (hh_inc),
        .load_i     (accept),
        .load_val_i (ld_v.hh),
        .value_o    (hh),
        .tc_o       (hh_tc)
    );

    assign sec_en   = sec_q;
    assign mm_en    = mm_en_q;
    assign hh_en    = hh_en_q;
    assign day_en   = day_q;
    assign load_err = err_q;

`ifdef TIMEKEEPER_ALARM_EN
    hms_t alarm_t_q;
    logic armed_q, alarm_q;
    logic [DIGIT_W-1:0] nxt_mm, nxt_hh;
    logic tick_match, load_match;

    // Time the coming tick lands on; only reaches :00 seconds on an ss wrap
    assign nxt_mm = mm_tc ? '0 : mm + 1'b1;
    assign nxt_hh = mm_tc ? (hh_tc ? '0 : hh + 1'b1) : hh;

    assign tick_match = mm_inc && (nxt_hh == alarm_t_q.hh) &&
                        (nxt_mm == alarm_t_q.mm);
    assign load_match = accept && (ld_v == alarm_t_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            alarm_t_q <= '0;
            armed_q   <= 1'b0;
            alarm_q   <= 1'b0;
        end else if (alarm_set) begin
            alarm_t_q <= '{hh: alarm_hh, mm: alarm_mm, ss: '0};
            armed_q   <= 1'b1;
            alarm_q   <= 1'b0;
        end else if (alarm_ack) begin
            armed_q <= 1'b0;
            alarm_q <= 1'b0;
        end else if (armed_q && (tick_match || load_match)) begin
            alarm_q <= 1'b1;
        end
    end

    assign alarm = alarm_q;
`else
    logic unused_alarm_in;

    assign unused_alarm_in = ^{alarm_set, alarm_hh, alarm_mm, alarm_ack};
    assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_timekeeper_hms.sv
// Scoreboard bench: seconds-of-day reference model versus timekeeper_hms.
module tb_timekeeper_hms;
    import timekeeper_pkg::*;

    localparam int T   = 4;
    localparam int HPD = 24;
    localparam int DAY = HPD * 3600;

    logic clk = 1'b0;
    logic reset = 1'b0, en = 1'b0, load = 1'b0;
    logic [5:0] ld_hh = '0, ld_mm = '0, ld_ss = '0;
    logic load_err;
    logic [5:0] hh, mm, ss;
    logic sec_en, mm_en, hh_en, day_en;
    logic alarm_set = 1'b0, alarm_ack = 1'b0;
    logic [5:0] alarm_hh = '0, alarm_mm = '0;
    logic alarm;

    typedef struct packed {
        logic [5:0] hh;
        logic [5:0] mm;
        logic [5:0] ss;
        logic sec, mn, hr, day, lerr, alm;
    } obs_t;

    obs_t expq[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int m_tod = 0, m_pre = 0, m_ahh = 0, m_amm = 0;
    bit m_armed = 0, m_alarm = 0;

    timekeeper_hms #(.TICKS_PER_SEC(T), .HOURS_PER_DAY(HPD)) dut (
        .clk(clk), .reset(reset), .en(en), .load(load),
        .ld_hh(ld_hh), .ld_mm(ld_mm), .ld_ss(ld_ss),
        .load_err(load_err), .hh(hh), .mm(mm), .ss(ss),
        .sec_en(sec_en), .mm_en(mm_en), .hh_en(hh_en), .day_en(day_en),
        .alarm_set(alarm_set), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm),
        .alarm_ack(alarm_ack), .alarm(alarm)
    );

    always #5 clk = ~clk;

    // Model one clock edge from the current inputs, queue the expected outputs.
    task automatic cycle();
        obs_t e;
        int nt;
        bit tick, ok, acc, match;
        e = '0;
        if (reset) begin
            m_tod = 0; m_pre = 0; m_armed = 0; m_alarm = 0;
            m_ahh = 0; m_amm = 0;
        end else begin
            tick  = en && (m_pre == T - 1);
            ok    = (ld_ss <= 59) && (ld_mm <= 59) && (ld_hh <= HPD - 1);
            acc   = load && ok;
            match = 0;
            if (acc) begin
                m_tod = ld_hh * 3600 + ld_mm * 60 + ld_ss;
                m_pre = 0;
                match = 1;
            end else begin
                e.lerr = load;
                if (en) m_pre = tick ? 0 : m_pre + 1;
                if (tick) begin
                    nt = (m_tod + 1) % DAY;
                    e.sec = 1;
                    e.mn  = (nt % 60 == 0);
                    e.hr  = (nt % 3600 == 0);
                    e.day = (nt == 0);
                    m_tod = nt;
                    match = 1;
                end
            end
`ifdef TIMEKEEPER_ALARM_EN
            match = match && m_armed && (m_tod / 3600 == m_ahh) &&
                    ((m_tod / 60) % 60 == m_amm) && (m_tod % 60 == 0);
            if (alarm_set) begin
                m_ahh = alarm_hh; m_amm = alarm_mm;
                m_armed = 1; m_alarm = 0;
            end else if (alarm_ack) begin
                m_armed = 0; m_alarm = 0;
            end else if (match) begin
                m_alarm = 1;
            end
`endif
        end
        e.hh  = 6'(m_tod / 3600);
        e.mm  = 6'((m_tod / 60) % 60);
        e.ss  = 6'(m_tod % 60);
        e.alm = m_alarm;
        expq.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n, input bit e);
        en = e;
        repeat (n) cycle();
    endtask

    task automatic do_load(input int h, input int m, input int s);
        load = 1'b1;
        ld_hh = 6'(h); ld_mm = 6'(m); ld_ss = 6'(s);
        cycle();
        load = 1'b0;
    endtask

    always @(negedge clk) begin
        obs_t e, a;
        cyc++;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            a = '{hh, mm, ss, sec_en, mm_en, hh_en, day_en, load_err, alarm};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs cyc=%0d got %0d:%0d:%0d s/m/h/d=%b%b%b%b err=%b alm=%b required %0d:%0d:%0d s/m/h/d=%b%b%b%b err=%b alm=%b",
                         cyc, a.hh, a.mm, a.ss, a.sec, a.mn, a.hr, a.day, a.lerr, a.alm,
                         e.hh, e.mm, e.ss, e.sec, e.mn, e.hr, e.day, e.lerr, e.alm);
            end
        end
    end

    initial begin
        #2;
        reset = 1'b1;
        cycle(); cycle();
        reset = 1'b0;
        idle(8, 1'b1);

        en = 1'b0;
        do_load(23, 59, 58);
        idle(9, 1'b1);

        en = 1'b0;
        do_load(24, 0, 0);
        do_load(0, 60, 0);
        do_load(12, 34, 56);
        idle(2, 1'b0);

        do_load(0, 0, 59);
        idle(3, 1'b1);
        do_load(5, 6, 7);
        idle(2, 1'b1);

        en = 1'b0;
        alarm_set = 1'b1; alarm_hh = 6'd0; alarm_mm = 6'd1;
        do_load(0, 0, 58);
        alarm_set = 1'b0;
        idle(12, 1'b1);
        alarm_ack = 1'b1;
        cycle();
        alarm_ack = 1'b0;
        en = 1'b0;
        do_load(0, 0, 58);
        idle(12, 1'b1);

        idle(2, 1'b1);
        reset = 1'b1;
        do_load(1, 2, 3);
        reset = 1'b0;
        idle(3, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 7) != 0);
            load = ($urandom_range(0, 39) == 0);
            ld_hh = ($urandom_range(0, 2) == 0) ? 6'd23 : 6'($urandom_range(0, 25));
            ld_mm = ($urandom_range(0, 2) == 0) ? 6'd59 : 6'($urandom_range(0, 61));
            ld_ss = 6'($urandom_range(48, 61));
            alarm_set = ($urandom_range(0, 149) == 0);
            alarm_hh = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom_range(0, 30));
            alarm_mm = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom_range(0, 63));
            alarm_ack = ($urandom_range(0, 199) == 0);
            reset = ($urandom_range(0, 999) == 0);
            cycle();
        end
        reset = 1'b0; load = 1'b0; alarm_set = 1'b0; alarm_ack = 1'b0;
        en = 1'b0;

        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending required 0", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
